// File: rtl/synth_pkg.sv
// Shared types for the key front-end of synth.
//   NUM_KEYS     : number of tone key channels
//   note_idx_t   : 4-bit key index (covers up to 16 keys)
//   key_vec_t    : one bit per key
//   prio_state_t : last-note priority FSM state
package synth_pkg;

  localparam int unsigned NUM_KEYS = 12;

  typedef logic [3:0]          note_idx_t;
  typedef logic [NUM_KEYS-1:0] key_vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } prio_state_t;

endpackage

// File: rtl/key_debouncer.sv
// One key channel: multi-flop synchroniser followed by a debounce counter.
//   master_clk : system clock, all state on the rising edge
//   reset      : synchronous active-high reset (key treated as released)
//   key_raw    : asynchronous bouncy key level
//   key_stable : debounced level, changes only after DEBOUNCE_CYCLES
//                consecutive synchronised samples disagree with it
module key_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 122880
) (
  input  logic master_clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_stable
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sync;

  assign sync       = sync_q[SYNC_STAGES-1];
  assign key_stable = stable_q;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], key_raw};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync == stable_q) begin
      // Any bounce back to the accepted level restarts the count.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/key_input_conditioner.sv
// Key front-end for synth: per-key synchronise + debounce, then monophonic
// last-note priority producing a one-hot key vector.
//   master_clk  : 12.288 MHz system clock
//   reset       : synchronous active-high reset
//   key_raw     : raw asynchronous keys, bit i = key i+1, 1 = pressed
//   key_stable  : debounced level of every key
//   active_key  : one-hot (or zero) selected key, bit i drives synth_key(i+1)
//   note_valid  : 1 when active_key is non-zero
//   note_index  : index of the selected key, 0 when note_valid = 0
//   note_change : one-cycle pulse whenever active_key changes
module key_input_conditioner #(
  parameter int unsigned NUM_KEYS        = 12,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 122880
) (
  input  logic                master_clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_stable,
  output logic [NUM_KEYS-1:0] active_key,
  output logic                note_valid,
  output logic [3:0]          note_index,
  output logic                note_change
);
  import synth_pkg::*;

  // Keeps only the lowest-index set bit.
  function automatic logic [NUM_KEYS-1:0] lowest_bit(input logic [NUM_KEYS-1:0] v);
    lowest_bit = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (v[i] && (lowest_bit == '0)) lowest_bit[i] = 1'b1;
    end
  endfunction

  function automatic note_idx_t onehot_index(input logic [NUM_KEYS-1:0] v);
    onehot_index = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) onehot_index = note_idx_t'(i);
    end
  endfunction

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .master_clk(master_clk),
      .reset     (reset),
      .key_raw   (key_raw[g]),
      .key_stable(key_stable[g])
    );
  end

  logic [NUM_KEYS-1:0] key_stable_dly_q;
  logic [NUM_KEYS-1:0] rise, fall;
  prio_state_t         state_q, state_d;
  logic [NUM_KEYS-1:0] active_q, active_d;
  note_idx_t           note_index_q, note_index_d;
  logic                note_valid_q, note_valid_d;
  logic                note_change_q, note_change_d;

  assign rise = key_stable & ~key_stable_dly_q;
  assign fall = ~key_stable & key_stable_dly_q;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (|rise) begin
          state_d  = HOLD;
          active_d = lowest_bit(rise);
        end
      end
      HOLD: begin
        // A press always wins, even when the selected key releases in the
        // same cycle; the fallback only applies to a pure release.
        if (|rise) begin
          active_d = lowest_bit(rise);
        end else if (|(fall & active_q)) begin
          if (|key_stable) begin
            active_d = lowest_bit(key_stable);
          end else begin
            active_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        active_d = '0;
      end
    endcase
    note_valid_d  = (state_d == HOLD);
    note_index_d  = onehot_index(active_d);
    note_change_d = (active_d != active_q);
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      key_stable_dly_q <= '0;
      state_q          <= IDLE;
      active_q         <= '0;
      note_index_q     <= '0;
      note_valid_q     <= 1'b0;
      note_change_q    <= 1'b0;
    end else begin
      key_stable_dly_q <= key_stable;
      state_q          <= state_d;
      active_q         <= active_d;
      note_index_q     <= note_index_d;
      note_valid_q     <= note_valid_d;
      note_change_q    <= note_change_d;
    end
  end

  assign active_key  = active_q;
  assign note_valid  = note_valid_q;
  assign note_index  = note_index_q;
  assign note_change = note_change_q;

endmodule

// File: doc/key_input_conditioner.md
# key_input_conditioner

Upstream front-end of `synth`. Takes the 12 raw, asynchronous, bouncy key inputs, synchronises and debounces each one, and applies monophonic last-note priority. Drives a one-hot key vector straight into `synth_key1..synth_key12`, so at most one tone key is ever asserted to the tone/half-period selection.

## Interface
- `NUM_KEYS`, 12, number of key channels (fixed at 12 for `synth`; the 4-bit index covers up to 16).
- `SYNC_STAGES`, 2, synchroniser flops per key (≥2).
- `DEBOUNCE_CYCLES`, 122880, cycles a new level must persist before acceptance (10 ms at 12.288 MHz; ≥2).

- `master_clk`  in  1  12.288 MHz system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset.
- `key_raw`  in  NUM_KEYS  asynchronous raw keys; bit i = key i+1, 1 = pressed.
- `key_stable`  out  NUM_KEYS  debounced level of every key.
- `active_key`  out  NUM_KEYS  one-hot (or zero) selected key; bit i drives `synth_key(i+1)`.
- `note_valid`  out  1  1 when `active_key` is non-zero.
- `note_index`  out  4  index of the selected key (0..NUM_KEYS-1); 0 when `note_valid`=0.
- `note_change`  out  1  one-cycle pulse whenever `active_key` changes value.

## Operation
- Per key: `SYNC_STAGES`-flop synchroniser → `sync`. Debounce counter `cnt` (width `$clog2(DEBOUNCE_CYCLES)`):
  - `sync == stable`: `cnt` ← 0.
  - `sync != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `sync`, `cnt` ← 0.
  - otherwise `cnt` ← `cnt+1`. Any bounce back to `stable` restarts the count from 0.
- Press edges `rise = stable & ~stable_d`, release edges `fall = ~stable & stable_d` (`stable_d` = `key_stable` delayed one cycle).
- Priority FSM, states IDLE (`note_valid`=0) and HOLD (`note_valid`=1):
  - IDLE, any `rise`: → HOLD; select lowest-index set bit of `rise`.
  - HOLD, any `rise`: reselect the lowest-index set bit of `rise` (newest press wins).
  - HOLD, no `rise`, `fall` on the selected key: if other keys are still stable-high, select the lowest-index one and stay in HOLD; else → IDLE.
  - HOLD, `fall` on a non-selected key only: no change.
  - A simultaneous `rise` and `fall` of the selected key resolve as the `rise` rule.
- `note_change` = registered (`active_key_next != active_key`).

## Timing
- Reset (one or more cycles): synchroniser flops, `stable`, `stable_d`, and `cnt` clear to 0 (keys treated as released). Outputs `key_stable`=0, `active_key`=0, `note_valid`=0, `note_index`=0, `note_change`=0. Reset mid-debounce discards the partial count. A key held through reset is re-accepted after full latency.
- Latency: a clean level first sampled at edge k gives a `key_stable` change at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. `active_key`, `note_valid`, `note_index`, and `note_change` update one edge later.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronisation never reaches `key_stable`.
- All outputs are registered; `active_key` is never multi-hot in any cycle.

## Structure
- `synth_pkg`: `NUM_KEYS` constant, `typedef logic [3:0] note_idx_t`, `typedef logic [NUM_KEYS-1:0] key_vec_t`, and FSM state enum `prio_state_t {IDLE, HOLD}`.
- Sub-module `key_debouncer`: one channel, containing the synchroniser and counter. Instantiated `NUM_KEYS` times in a generate loop. The top holds the edge detection, the priority FSM, and the lowest-set-bit encoder.

## Test plan
Run with `DEBOUNCE_CYCLES`=8 and `SYNC_STAGES`=2.
- **Reset:** assert `reset` 3 cycles with `key_raw`=12'hFFF. All outputs are 0 during reset. After release, `key_stable`=12'hFFF on the 9th edge, and `active_key`=12'h001, `note_index`=0, `note_change`=1 one edge later.
- **Debounce:** key 1 toggles every 3 cycles for 40 cycles, then holds 1. `key_stable[0]` stays 0 throughout the bouncing and rises exactly 9 edges after the final toggle is sampled.
- **Last-note priority:** press key 1, then key 6 (bit 5) 20 cycles later. `note_index` goes 0 → 5, `active_key`=12'h020, with one `note_change` pulse per switch.
- **Release fallback:** while holding keys 3, 6, and 10 with 10 selected, release key 10. The result is `note_index`=2. Release key 3: `note_index`=5. Release key 6: `note_valid`=0, `active_key`=0.
- **Simultaneous press:** keys 4 and 9 rise in the same cycle → `note_index`=3. Releasing non-selected key 9 causes no `note_change`.
- **Reset mid-operation:** reset while key 6 is held and while a key 2 count sits at 5. All state clears to 0, then key 6 is re-accepted 9 edges after reset deasserts.
